// File: rtl/rot_frame_buffer.sv
// Frame buffer fed pixel-by-pixel by an image rotator, read back one row per cycle for display.
// Define ROT_FB_DOUBLE_BUFFER_EN for ping-pong banks; the default build uses one shared bank.
module rot_frame_buffer #(
  parameter int ROWS = 48,
  parameter int COLS = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [5:0]      pix_row,
  input  logic [2:0]      pix_col,
  input  logic            pix_bit,
  input  logic            pix_last,
  input  logic [5:0]      rd_row,
  output logic [COLS-1:0] rd_data,
  output logic            frame_ready,
  output logic [7:0]      frame_cnt,
  output logic            err_oob
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] ROWS_LIM = 7'(ROWS);
  localparam logic [3:0] COLS_LIM = 4'(COLS);
  localparam logic [5:0] CLR_LAST = 6'(ROWS - 1);

  state_t          state_q;
  state_t          state_d;
  logic [5:0]      clr_row_q;
  logic            disp_vld_q;
  logic            xfer;
  logic            pix_in_range;
  logic            rd_in_range;
  logic            clr_we;
  logic            clr_done;
  logic            pix_we;
  logic [COLS-1:0] rd_word;

  assign xfer         = pix_valid && pix_ready;
  assign pix_in_range = ({1'b0, pix_row} < ROWS_LIM) && ({1'b0, pix_col} < COLS_LIM);
  assign rd_in_range  = {1'b0, rd_row} < ROWS_LIM;
  assign clr_we       = (state_q == CLEAR);
  assign clr_done     = clr_we && (clr_row_q == CLR_LAST);
  assign pix_we       = xfer && pix_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_done) state_d = FILL;
      FILL:    if (xfer && pix_last) state_d = COMMIT;
      COMMIT:  state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Moore outputs keep pix_ready independent of pix_valid.
  always_comb begin
    pix_ready   = 1'b0;
    frame_ready = 1'b0;
    case (state_q)
      FILL:    pix_ready = 1'b1;
      COMMIT:  frame_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_row_q <= '0;
      frame_cnt <= '0;
      err_oob   <= 1'b0;
    end else begin
      if (clr_we) clr_row_q <= clr_done ? 6'd0 : clr_row_q + 6'd1;
      if (state_q == COMMIT) frame_cnt <= frame_cnt + 8'd1;
      if (xfer && !pix_in_range) err_oob <= 1'b1;
    end
  end

`ifdef ROT_FB_DOUBLE_BUFFER_EN
  logic            disp_sel_q;
  logic            wr_sel;
  logic [COLS-1:0] mem [2][ROWS];

  assign wr_sel = ~disp_sel_q;

  // The display bank is blank until the first frame has been committed into it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_sel_q <= 1'b0;
      disp_vld_q <= 1'b0;
    end else if (state_q == COMMIT) begin
      disp_sel_q <= ~disp_sel_q;
      disp_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem[wr_sel][clr_row_q] <= '0;
    if (pix_we) mem[wr_sel][pix_row][pix_col] <= pix_bit;
  end

  assign rd_word = rd_in_range ? mem[disp_sel_q][rd_row] : '0;
`else
  logic [COLS-1:0] mem [ROWS];

  // Rows not yet reached by the first clear pass read as blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        disp_vld_q <= 1'b0;
    else if (clr_done) disp_vld_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_row_q] <= '0;
    if (pix_we) mem[pix_row][pix_col] <= pix_bit;
  end

  assign rd_word = rd_in_range ? mem[rd_row] : '0;
`endif

  // Registered read; same-edge writes are not yet visible in rd_word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= disp_vld_q ? rd_word : '0;
  end

endmodule

// File: tb/tb_rot_frame_buffer.sv
// Directed bench for rot_frame_buffer; expectations adapt to ROT_FB_DOUBLE_BUFFER_EN.
module tb_rot_frame_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [5:0] pix_row = '0;
  logic [2:0] pix_col = '0;
  logic       pix_bit = 1'b0;
  logic       pix_last = 1'b0;
  logic [5:0] rd_row = '0;
  logic [5:0] rd_data;
  logic       frame_ready;
  logic [7:0] frame_cnt;
  logic       err_oob;

  int checks = 0;
  int failures = 0;

  rot_frame_buffer #(.ROWS(48), .COLS(6)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_row(pix_row), .pix_col(pix_col), .pix_bit(pix_bit), .pix_last(pix_last),
    .rd_row(rd_row), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_cnt(frame_cnt), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one pixel (called at a negedge), hold it through stalls, return at the negedge after transfer.
  task automatic send_pixel(input logic [5:0] r, input logic [2:0] c, input logic b, input logic l);
    int n;
    pix_row = r; pix_col = c; pix_bit = b; pix_last = l; pix_valid = 1'b1;
    n = 0;
    while (pix_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (pix_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: pix_ready=%b after %0d cycles, required 1", pix_ready, n);
    end
    step();
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  task automatic test_reset();
    pix_valid = 1'b1;
    repeat (2) step();
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL rst_frame_ready: got %b want 0", frame_ready); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL rst_cnt: got %0d want 0", frame_cnt); end
    checks++; if (err_oob !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", err_oob); end
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL rst_rd: got %b want 0", rd_data); end
    reset = 1'b1;
    for (int i = 0; i < 48; i++) begin
      rd_row = 6'(i);
      checks++;
      if (pix_ready !== 1'b0) begin failures++; $display("FAIL clear_ready cyc%0d: got %b want 0", i + 1, pix_ready); end
      step();
      checks++;
      if (rd_data !== 6'd0) begin failures++; $display("FAIL clear_rd row%0d: got %b want 0", i, rd_data); end
    end
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL ready_rise: got %b want 1", pix_ready); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL cnt_after_clear: got %0d want 0", frame_cnt); end
    pix_valid = 1'b0;
  endtask

  task automatic test_frame_commit();
    logic [5:0] exp_e;
    logic [5:0] exp_e1;
    rd_row = 6'd5;
    send_pixel(6'd5, 3'd0, 1'b1, 1'b0);
    send_pixel(6'd5, 3'd1, 1'b1, 1'b0);
    send_pixel(6'd5, 3'd2, 1'b0, 1'b0);
    send_pixel(6'd5, 3'd3, 1'b1, 1'b0);
    send_pixel(6'd5, 3'd4, 1'b0, 1'b0);
    send_pixel(6'd5, 3'd5, 1'b1, 1'b1);
`ifdef ROT_FB_DOUBLE_BUFFER_EN
    exp_e = 6'b000000; exp_e1 = 6'b000000;
`else
    exp_e = 6'b001011; exp_e1 = 6'b101011;
`endif
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL f1_pulse: got %b want 1", frame_ready); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL f1_cnt_pre: got %0d want 0", frame_cnt); end
    checks++; if (rd_data !== exp_e) begin failures++; $display("FAIL f1_prewrite_rd: got %b want %b", rd_data, exp_e); end
    step();
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL f1_pulse_end: got %b want 0", frame_ready); end
    checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL f1_cnt: got %0d want 1", frame_cnt); end
    checks++; if (rd_data !== exp_e1) begin failures++; $display("FAIL f1_rd_commit: got %b want %b", rd_data, exp_e1); end
    step();
    checks++; if (rd_data !== 6'b101011) begin failures++; $display("FAIL f1_rd: got %b want 101011", rd_data); end
  endtask

  task automatic test_double_buffer();
    logic [5:0] exp_hold;
    logic [5:0] exp_c;
`ifdef ROT_FB_DOUBLE_BUFFER_EN
    exp_hold = 6'b101011; exp_c = 6'b101011;
`else
    exp_hold = 6'b000100; exp_c = 6'b010100;
`endif
    rd_row = 6'd5;
    send_pixel(6'd5, 3'd2, 1'b1, 1'b0);
    send_pixel(6'd5, 3'd0, 1'b0, 1'b0);
    checks++; if (rd_data !== exp_hold) begin failures++; $display("FAIL f2_partial_rd: got %b want %b", rd_data, exp_hold); end
    send_pixel(6'd5, 3'd4, 1'b1, 1'b1);
    checks++; if (rd_data !== exp_hold) begin failures++; $display("FAIL f2_last_rd: got %b want %b", rd_data, exp_hold); end
    step();
    checks++; if (frame_cnt !== 8'd2) begin failures++; $display("FAIL f2_cnt: got %0d want 2", frame_cnt); end
    checks++; if (rd_data !== exp_c) begin failures++; $display("FAIL f2_commit_rd: got %b want %b", rd_data, exp_c); end
    step();
    checks++; if (rd_data !== 6'b010100) begin failures++; $display("FAIL f2_rd: got %b want 010100", rd_data); end
  endtask

  task automatic test_oob();
    send_pixel(6'd0, 3'd6, 1'b1, 1'b0);
    checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_col: got %b want 1", err_oob); end
    send_pixel(6'd48, 3'd0, 1'b1, 1'b0);
    checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_row: got %b want 1", err_oob); end
    send_pixel(6'd1, 3'd0, 1'b1, 1'b0);
    checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_sticky: got %b want 1", err_oob); end
    send_pixel(6'd48, 3'd7, 1'b1, 1'b1);
    step();
    checks++; if (frame_cnt !== 8'd3) begin failures++; $display("FAIL oob_last_cnt: got %0d want 3", frame_cnt); end
    rd_row = 6'd0;
    step();
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL oob_row0: got %b want 000000", rd_data); end
    rd_row = 6'd1;
    step();
    checks++; if (rd_data !== 6'b000001) begin failures++; $display("FAIL oob_row1: got %b want 000001", rd_data); end
    rd_row = 6'd48;
    step();
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL rd_oob_row: got %b want 000000", rd_data); end
    checks++; if (err_oob !== 1'b1) begin failures++; $display("FAIL oob_held: got %b want 1", err_oob); end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 10; i++) send_pixel(6'(i), 3'd0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL mrst_ready: got %b want 0", pix_ready); end
    checks++; if (err_oob !== 1'b0) begin failures++; $display("FAIL mrst_err: got %b want 0", err_oob); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL mrst_cnt: got %0d want 0", frame_cnt); end
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL mrst_rd: got %b want 0", rd_data); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 48; i++) begin
      rd_row = 6'(i);
      checks++;
      if (pix_ready !== 1'b0) begin failures++; $display("FAIL mrst_clear_ready cyc%0d: got %b want 0", i + 1, pix_ready); end
      step();
      checks++;
      if (rd_data !== 6'd0) begin failures++; $display("FAIL mrst_rd row%0d: got %b want 0", i, rd_data); end
    end
    checks++; if (pix_ready !== 1'b1) begin failures++; $display("FAIL mrst_ready_rise: got %b want 1", pix_ready); end
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL mrst_cnt_after: got %0d want 0", frame_cnt); end
    rd_row = 6'd3;
    step();
    checks++; if (rd_data !== 6'd0) begin failures++; $display("FAIL mrst_fill_rd: got %b want 0", rd_data); end
  endtask

  task automatic test_wrap();
    rd_row = 6'd7;
    send_pixel(6'd7, 3'd3, 1'b1, 1'b1);
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL single_pulse: got %b want 1", frame_ready); end
    step();
    checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
    step();
    checks++; if (rd_data !== 6'b001000) begin failures++; $display("FAIL single_rd: got %b want 001000", rd_data); end
    for (int i = 0; i < 254; i++) send_pixel(6'd0, 3'd0, 1'b1, 1'b1);
    step();
    checks++; if (frame_cnt !== 8'd255) begin failures++; $display("FAIL cnt_255: got %0d want 255", frame_cnt); end
    send_pixel(6'd0, 3'd0, 1'b1, 1'b1);
    checks++; if (frame_ready !== 1'b1) begin failures++; $display("FAIL wrap_pulse: got %b want 1", frame_ready); end
    step();
    checks++; if (frame_cnt !== 8'd0) begin failures++; $display("FAIL cnt_wrap: got %0d want 0", frame_cnt); end
    checks++; if (frame_ready !== 1'b0) begin failures++; $display("FAIL wrap_pulse_end: got %b want 0", frame_ready); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame_commit();
    test_double_buffer();
    test_oob();
    test_midframe_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
